// File: rtl/forward_reg_pkg.sv
// Shared constants for the forward register slice.
package forward_reg_pkg;

  // Payload width used when an instance does not override W.
  localparam int unsigned FWD_DEFAULT_W = 32;

endpackage : forward_reg_pkg

// File: rtl/forward_reg.sv
// Single-stage valid/ready forward slice: payload and valid are registered,
// while the ready path stays combinational (output_ready -> input_ready).
module forward_reg
  import forward_reg_pkg::*;
#(
  parameter int unsigned W = FWD_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         input_valid,
  input  logic [W-1:0] input_payload,
  output logic         input_ready,
  output logic         output_valid,
  output logic [W-1:0] output_payload,
  input  logic         output_ready
);

  logic         r_valid;
  logic [W-1:0] r_payload;
  logic         w_load;

  // Accept a new beat when empty or when the held beat leaves this cycle.
  assign w_load      = ~r_valid | output_ready;
  assign input_ready = w_load;

  // Valid and payload flops; payload only updates on a real incoming beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (w_load) begin
      r_valid <= input_valid;
      if (input_valid) begin
        r_payload <= input_payload;
      end
    end
  end

  assign output_valid   = r_valid;
  assign output_payload = r_payload;

endmodule : forward_reg

// File: tb/tb_forward_reg.sv
// Directed and random checks of forward_reg with a queue scoreboard.
module tb_forward_reg;

  logic clk = 1'b0;
  logic rst_n;

  // Main W=8 instance
  logic       iv, ir, ov, ordy;
  logic [7:0] ip, op;

  // W=1 and W=160 instances
  logic         iv1, ir1, ov1;
  logic [0:0]   ip1, op1;
  logic         iv160, ir160, ov160;
  logic [159:0] ip160, op160;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  forward_reg #(.W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .input_valid(iv), .input_payload(ip), .input_ready(ir),
    .output_valid(ov), .output_payload(op), .output_ready(ordy)
  );

  forward_reg #(.W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .input_valid(iv1), .input_payload(ip1), .input_ready(ir1),
    .output_valid(ov1), .output_payload(op1), .output_ready(1'b1)
  );

  forward_reg #(.W(160)) u_w160 (
    .clk(clk), .rst_n(rst_n),
    .input_valid(iv160), .input_payload(ip160), .input_ready(ir160),
    .output_valid(ov160), .output_payload(op160), .output_ready(1'b1)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the W=8 instance. Called at posedge+1; returns at posedge+1.
  task automatic cycle(input logic v, input logic [7:0] p, input logic r);
    logic exp_ready;
    logic [7:0] exp_p;
    iv = v; ip = p; ordy = r;
    #1;
    exp_ready = (q.size() == 0) || r;
    chk("input_ready", ir, exp_ready);
    if (q.size() != 0 && r) begin
      exp_p = q.pop_front();
      chk("handshake_payload", op, exp_p);
    end
    if (v && exp_ready) q.push_back(p);
    @(posedge clk); #1;
    chk("output_valid", ov, q.size() != 0);
    if (q.size() != 0) chk("output_payload", op, q[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    iv = 0; ip = '0; ordy = 1'b1;
    iv1 = 0; ip1 = '0; iv160 = 0; ip160 = '0;
    #1;
    chk("rst_valid", ov, 1'b0);
    chk("rst_payload", op, 8'h00);
    chk("rst_ready", ir, 1'b1);
    iv = 1'b1; ip = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", ov, 1'b0);
    chk("rst_hold_payload", op, 8'h00);
    iv = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", ov, 1'b0);

    // Streaming 0x01..0x10 with output_ready held high
    for (int unsigned i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1);
    // Drain with no fill
    cycle(1'b0, 8'h00, 1'b1);
    chk("drain_valid", ov, 1'b0);

    // Backpressure: load 0xA5, stall 5 cycles while offering 0x3C
    cycle(1'b1, 8'hA5, 1'b1);
    for (int unsigned i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h3C, 1'b0);
      chk("bp_payload", op, 8'hA5);
      chk("bp_ready", ir, 1'b0);
    end
    cycle(1'b1, 8'h3C, 1'b1);
    chk("bp_release_payload", op, 8'h3C);
    cycle(1'b0, 8'h00, 1'b1);
    chk("bp_drained", ov, 1'b0);

    // Reset mid-stream drops the held beat without a clock edge
    cycle(1'b1, 8'h77, 1'b0);
    iv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov, 1'b0);
    chk("async_rst_payload", op, 8'h00);
    chk("async_rst_ready", ir, 1'b1);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Random valid/ready traffic
    for (int unsigned i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    cycle(1'b0, 8'h00, 1'b1);
    chk("random_drained", ov, 1'b0);
    chk("random_queue_empty", 160'(q.size()), 160'd0);

    // Width extremes
    iv1 = 1'b1; ip1 = 1'b1; iv160 = 1'b1; ip160 = '1;
    @(posedge clk); #1;
    chk("w1_ones_valid", ov1, 1'b1);
    chk("w1_ones", op1, 1'b1);
    chk("w160_ones_valid", ov160, 1'b1);
    chk("w160_ones", op160, {160{1'b1}});
    ip1 = 1'b0; ip160 = {20{8'h55}};
    @(posedge clk); #1;
    chk("w1_zero", op1, 1'b0);
    chk("w160_alt55", op160, {20{8'h55}});
    ip160 = {20{8'hAA}};
    @(posedge clk); #1;
    chk("w160_altAA", op160, {20{8'hAA}});
    iv1 = 1'b0; iv160 = 1'b0;
    @(posedge clk); #1;
    chk("w1_drain", ov1, 1'b0);
    chk("w160_drain", ov160, 1'b0);
    chk("w160_ready", ir160, 1'b1);
    chk("w1_ready", ir1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_forward_reg
